adc_seq_ctrl: RTL and testbench

ADC_SEQ_CTRL -- requirements
Module: adc_seq_ctrl

---
 rtl/adc_seq_ctrl.sv | 252 +++++++++++++++++++++++++
 tb/tb_adc_seq_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/adc_seq_ctrl.sv
// EBI-mapped serial ADC sequencer: program frames, round-robin conversions, per-channel SAMPLE/SEQUENCE registers.
// Optional sample FIFO is built when ADC_SEQ_FIFO_EN is defined.
module adc_seq_ctrl #(
  parameter int NUM_CH     = 8,
  parameter int SAMPLE_W   = 16,
  parameter int POSITION   = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [18:0] addr,
  input  logic [15:0] data_in,
  input  logic        enable,
  input  logic        wr,
  input  logic        re,
  output logic [15:0] data_out,
  output logic        new_sample,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic        adc_din,
  input  logic        adc_dout
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PROG  = 3'd1;
  localparam logic [2:0] S_CONV  = 3'd2;
  localparam logic [2:0] S_STORE = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  localparam int         CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [5:0] LAST_HALF = 6'(2 * SAMPLE_W - 1);
  localparam logic [4:0] NUM_CH_L  = 5'(NUM_CH);
  localparam logic [10:0] POS_L    = 11'(POSITION);

  logic [2:0]          r_state;
  logic                r_cs_n, r_sclk, r_din, r_new_sample;
  logic [15:0]         r_data_out;
  logic [NUM_CH-1:0]   r_ch_mask;
  logic [15:0]         r_divide, r_div_active, r_div_cnt;
  logic [5:0]          r_half_cnt;
  logic [15:0]         r_prog_word, r_exec_word, r_last_exec;
  logic                r_prog_pending;
  logic [SAMPLE_W-1:0] r_tx, r_rx;
  logic [CH_W-1:0]     r_cur_ch, r_last_ch;
  logic [15:0]         r_sample [0:NUM_CH-1];
  logic [15:0]         r_seq    [0:NUM_CH-1];

  logic                w_sel, w_wr_sel, w_rd_sel, w_ch_ok, w_tick, w_busy, w_start;
  logic [3:0]          w_cmd;
  logic [CH_W-1:0]     w_rd_idx, w_next_ch;
  logic [15:0]         w_conv_word, w_cap16, w_fifo_head;
  logic [SAMPLE_W-1:0] w_conv_frame, w_prog_frame;
  logic [$clog2(FIFO_DEPTH):0] w_fifo_cnt;
  logic                w_fifo_ovf;

  assign w_sel        = enable && (addr[18:8] == POS_L);
  assign w_wr_sel     = w_sel && wr;
  assign w_rd_sel     = w_sel && re;
  assign w_cmd        = addr[3:0];
  assign w_ch_ok      = {1'b0, addr[7:4]} < NUM_CH_L;
  assign w_rd_idx     = addr[4 +: CH_W];
  assign w_tick       = (r_div_cnt == r_div_active);
  assign w_busy       = (r_state != S_IDLE);
  assign w_start      = (r_state == S_IDLE) && (r_prog_pending || (|r_ch_mask));
  assign w_conv_word  = {1'b0, 4'(w_next_ch), 11'd0};
  assign w_conv_frame = w_conv_word[15 -: SAMPLE_W];
  assign w_prog_frame = r_prog_word[SAMPLE_W-1:0];
  assign w_cap16      = 16'(r_rx);

  assign data_out   = r_data_out;
  assign new_sample = r_new_sample;
  assign adc_cs_n   = r_cs_n;
  assign adc_sclk   = r_sclk;
  assign adc_din    = r_din;

  // Round-robin: the smallest upward distance from the last converted channel wins.
  always_comb begin
    int idx;
    idx       = 0;
    w_next_ch = r_last_ch;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = int'(r_last_ch) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (r_ch_mask[idx]) w_next_ch = CH_W'(idx);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_cs_n         <= 1'b1;
      r_sclk         <= 1'b0;
      r_din          <= 1'b0;
      r_new_sample   <= 1'b0;
      r_ch_mask      <= '0;
      r_divide       <= '0;
      r_div_active   <= '0;
      r_div_cnt      <= '0;
      r_half_cnt     <= '0;
      r_prog_word    <= '0;
      r_prog_pending <= 1'b0;
      r_exec_word    <= '0;
      r_last_exec    <= '0;
      r_tx           <= '0;
      r_rx           <= '0;
      r_cur_ch       <= '0;
      r_last_ch      <= CH_W'(NUM_CH - 1);
      for (int i = 0; i < NUM_CH; i++) begin
        r_sample[i] <= '0;
        r_seq[i]    <= '0;
      end
    end else begin
      r_new_sample <= 1'b0;
      if (w_wr_sel && w_cmd == 4'h1) r_ch_mask   <= data_in[NUM_CH-1:0];
      if (w_wr_sel && w_cmd == 4'h2) r_divide    <= data_in;
      if (w_wr_sel && w_cmd == 4'h4) r_prog_word <= data_in;
      // Pending is consumed when PROG starts; a coinciding PROGRAM write keeps it set.
      if (w_wr_sel && w_cmd == 4'h4)                 r_prog_pending <= 1'b1;
      else if (r_state == S_IDLE && r_prog_pending) r_prog_pending <= 1'b0;

      if (w_start) begin
        r_cs_n       <= 1'b0;
        r_sclk       <= 1'b0;
        r_div_active <= r_divide;
        r_div_cnt    <= '0;
        r_half_cnt   <= '0;
        r_rx         <= '0;
      end

      case (r_state)
        S_IDLE: begin
          if (r_prog_pending) begin
            r_state     <= S_PROG;
            r_exec_word <= r_prog_word;
            r_din       <= w_prog_frame[SAMPLE_W-1];
            r_tx        <= w_prog_frame << 1;
          end else if (|r_ch_mask) begin
            r_state   <= S_CONV;
            r_cur_ch  <= w_next_ch;
            r_last_ch <= w_next_ch;
            r_din     <= w_conv_frame[SAMPLE_W-1];
            r_tx      <= w_conv_frame << 1;
          end
        end
        S_PROG, S_CONV: begin
          if (w_tick) begin
            r_div_cnt  <= '0;
            r_sclk     <= ~r_sclk;
            r_half_cnt <= r_half_cnt + 6'd1;
            if (!r_sclk) begin
              r_rx <= {r_rx[SAMPLE_W-2:0], adc_dout};
            end else if (r_half_cnt == LAST_HALF) begin
              r_cs_n     <= 1'b1;
              r_din      <= 1'b0;
              r_half_cnt <= '0;
              if (r_state == S_PROG) begin
                r_last_exec <= r_exec_word;
                r_state     <= S_GAP;
              end else begin
                r_state <= S_STORE;
              end
            end else begin
              r_din <= r_tx[SAMPLE_W-1];
              r_tx  <= r_tx << 1;
            end
          end else begin
            r_div_cnt <= r_div_cnt + 16'd1;
          end
        end
        S_STORE: begin
          r_sample[r_cur_ch] <= w_cap16;
          r_seq[r_cur_ch]    <= r_seq[r_cur_ch] + 16'd1;
          r_new_sample       <= 1'b1;
          r_state            <= S_GAP;
          r_div_cnt          <= '0;
          r_half_cnt         <= '0;
        end
        S_GAP: begin
          if (w_tick) begin
            r_div_cnt  <= '0;
            r_half_cnt <= r_half_cnt + 6'd1;
            if (r_half_cnt[0]) r_state <= S_IDLE;
          end else begin
            r_div_cnt <= r_div_cnt + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !w_rd_sel) begin
      r_data_out <= '0;
    end else begin
      case (w_cmd)
        4'h7:    r_data_out <= w_ch_ok ? r_sample[w_rd_idx] : 16'd0;
        4'h8:    r_data_out <= w_ch_ok ? r_seq[w_rd_idx] : 16'd0;
        4'h9:    r_data_out <= 16'h0ADD;
        4'hA:    r_data_out <= {8'(w_fifo_cnt), 5'd0, w_fifo_ovf, r_prog_pending, w_busy};
        4'hB:    r_data_out <= r_last_exec;
        4'hC:    r_data_out <= (w_fifo_cnt != '0) ? w_fifo_head : 16'd0;
        default: r_data_out <= 16'd0;
      endcase
    end
  end

`ifdef ADC_SEQ_FIFO_EN
  localparam int        AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  logic [15:0]   r_fifo_mem [0:FIFO_DEPTH-1];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_fifo_cnt;
  logic          r_fifo_ovf;
  logic          w_push, w_pop, w_push_ok;

  assign w_push    = (r_state == S_STORE);
  assign w_pop     = w_rd_sel && (w_cmd == 4'hC) && (r_fifo_cnt != '0);
  // When full, a push is only accepted if a pop frees the head slot in the same clk.
  assign w_push_ok = w_push && ((r_fifo_cnt != FULL_CNT) || w_pop);

  always_ff @(posedge clk) begin
    if (w_push_ok) r_fifo_mem[r_wr_ptr] <= {4'(r_cur_ch), w_cap16[11:0]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
      r_fifo_ovf <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push_ok && !w_pop)      r_fifo_cnt <= r_fifo_cnt + 1'b1;
      else if (!w_push_ok && w_pop) r_fifo_cnt <= r_fifo_cnt - 1'b1;
      if (w_push && !w_push_ok)              r_fifo_ovf <= 1'b1;
      else if (w_wr_sel && w_cmd == 4'hA)    r_fifo_ovf <= 1'b0;
    end
  end

  assign w_fifo_cnt  = r_fifo_cnt;
  assign w_fifo_ovf  = r_fifo_ovf;
  assign w_fifo_head = r_fifo_mem[r_rd_ptr];
`else
  assign w_fifo_cnt  = '0;
  assign w_fifo_ovf  = 1'b0;
  assign w_fifo_head = 16'd0;
`endif

endmodule

// File: tb/tb_adc_seq_ctrl.sv
// Directed bench for adc_seq_ctrl: bus decode, program frame, round-robin conversions, reset abort, optional FIFO.
module tb_adc_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [18:0] addr = '0;
  logic [15:0] data_in = '0;
  logic        enable = 1'b0, wr = 1'b0, re = 1'b0;
  logic [15:0] data_out;
  logic        new_sample, adc_cs_n, adc_sclk, adc_din;
  logic        adc_dout = 1'b0;

  int          passed = 0, total = 0;
  logic [10:0] pos_sel = 11'd3;
  logic [15:0] adc_val = '0;
  logic [15:0] rd;
  logic [15:0] exp_status;
  int          base;

  // Bus monitor / ADC model state
  logic        prev_cs = 1'b1, prev_sclk = 1'b0;
  logic [15:0] adc_sr = '0, din_sr = '0;
  int          cs_len = 0, frame_count = 0, ns_count = 0;
  logic [15:0] frame_word [64];
  int          frame_len  [64];

  always #5 clk = ~clk;

  adc_seq_ctrl #(.NUM_CH(8), .SAMPLE_W(16), .POSITION(3), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .addr(addr), .data_in(data_in), .enable(enable),
    .wr(wr), .re(re), .data_out(data_out), .new_sample(new_sample),
    .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .adc_din(adc_din), .adc_dout(adc_dout)
  );

  // ADC shifts its word out MSB first, advancing on sclk falling edges; frames are logged at cs_n release.
  always @(negedge clk) begin
    if (new_sample) ns_count++;
    if (prev_cs && !adc_cs_n) begin
      adc_sr = adc_val;
      cs_len = 0;
      din_sr = '0;
    end else if (!adc_cs_n && prev_sclk && !adc_sclk) begin
      adc_sr = adc_sr << 1;
    end
    if (!adc_cs_n) cs_len++;
    if (!adc_cs_n && !prev_sclk && adc_sclk) din_sr = {din_sr[14:0], adc_din};
    if (!prev_cs && adc_cs_n && frame_count < 64) begin
      frame_word[frame_count] = din_sr;
      frame_len[frame_count]  = cs_len;
      frame_count++;
    end
    adc_dout  = adc_sr[15];
    prev_cs   = adc_cs_n;
    prev_sclk = adc_sclk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic bus_write(input logic [3:0] cmd, input logic [15:0] d);
    @(negedge clk);
    addr = {pos_sel, 4'd0, cmd}; data_in = d; enable = 1'b1; wr = 1'b1;
    @(negedge clk);
    enable = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] cmd, input logic [3:0] ch, output logic [15:0] d);
    @(negedge clk);
    addr = {pos_sel, ch, cmd}; enable = 1'b1; re = 1'b1;
    @(negedge clk);
    enable = 1'b0; re = 1'b0;
    d = data_out;
  endtask

  task automatic wait_frames(input int target, input string tag);
    int n = 0;
    while (frame_count < target && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(frame_count >= target), 32'd1);
  endtask

  task automatic wait_cs(input logic lvl, input string tag);
    int n = 0;
    while (adc_cs_n !== lvl && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(adc_cs_n), 32'(lvl));
  endtask

  task automatic idle_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset state and static decode
    idle_clks(3);
    reset = 1'b0;
    check("rst_pins", {28'd0, adc_cs_n, adc_sclk, adc_din, new_sample}, 32'h8);
    check("rst_dout", 32'(data_out), 32'h0);
    bus_read(4'hA, 4'd0, rd); check("rst_status", 32'(rd), 32'h0);
    bus_read(4'h9, 4'd0, rd); check("id", 32'(rd), 32'h0ADD);
    pos_sel = 11'd5;
    bus_read(4'h9, 4'd0, rd); check("id_wrong_pos", 32'(rd), 32'h0);
    pos_sel = 11'd3;
    bus_read(4'h5, 4'd0, rd); check("undef_cmd", 32'(rd), 32'h0);

    // Program frame at DIVIDE=1
    bus_write(4'h2, 16'd1);
    bus_write(4'h4, 16'h8310);
    bus_read(4'hA, 4'd0, rd); check("status_prog", 32'(rd), 32'h0001);
    wait_frames(1, "prog_timeout");
    check("prog_len", 32'(frame_len[0]), 32'd64);
    check("prog_din", 32'(frame_word[0]), 32'h8310);
    bus_read(4'hB, 4'd0, rd); check("last_exec", 32'(rd), 32'h8310);
    check("prog_no_pulse", 32'(ns_count), 32'd0);

    // Round-robin over channels 0 and 2
    adc_val = 16'h1234;
    bus_write(4'h1, 16'h0005);
    wait_frames(4, "rr_timeout");
    bus_write(4'h1, 16'h0000);
    idle_clks(20);
    check("rr_frames", 32'(frame_count), 32'd4);
    check("rr_f1_ch0", 32'(frame_word[1]), 32'h0000);
    check("rr_f2_ch2", 32'(frame_word[2]), 32'h1000);
    check("rr_f3_ch0", 32'(frame_word[3]), 32'h0000);
    check("rr_conv_len", 32'(frame_len[2]), 32'd64);
    check("rr_pulses", 32'(ns_count), 32'd3);
    bus_read(4'h7, 4'd2, rd); check("sample2", 32'(rd), 32'h1234);
    bus_read(4'h8, 4'd2, rd); check("seq2", 32'(rd), 32'd1);
    bus_read(4'h8, 4'd0, rd); check("seq0", 32'(rd), 32'd2);
    bus_read(4'h7, 4'd1, rd); check("sample1_masked", 32'(rd), 32'h0);
    bus_read(4'h7, 4'd8, rd); check("sample_ch8", 32'(rd), 32'h0);

    // PROGRAM during a conversion; SAMPLE read in the STORE clk
    adc_val = 16'h0ABC;
    base = frame_count;
    bus_write(4'h1, 16'h0002);
    wait_cs(1'b0, "conv_start");
    idle_clks(20);
    bus_write(4'h4, 16'h00F0);
    wait_cs(1'b1, "conv_end");
    addr = {pos_sel, 4'd1, 4'h7}; enable = 1'b1; re = 1'b1;
    @(negedge clk);
    enable = 1'b0; re = 1'b0;
    check("sample_store_clk", 32'(data_out), 32'h0);
    wait_frames(base + 3, "mid_timeout");
    bus_write(4'h1, 16'h0000);
    idle_clks(20);
    check("mid_frames", 32'(frame_count), 32'(base + 3));
    check("mid_f0_conv", 32'(frame_word[base]), 32'h0800);
    check("mid_f1_prog", 32'(frame_word[base + 1]), 32'h00F0);
    check("mid_f2_conv", 32'(frame_word[base + 2]), 32'h0800);
    bus_read(4'h7, 4'd1, rd); check("sample1", 32'(rd), 32'h0ABC);
    bus_read(4'h8, 4'd1, rd); check("seq1", 32'(rd), 32'd2);
    bus_read(4'hB, 4'd0, rd); check("last_exec2", 32'(rd), 32'h00F0);
    check("mid_pulses", 32'(ns_count), 32'd5);
`ifdef ADC_SEQ_FIFO_EN
    exp_status = 16'h0404;
`else
    exp_status = 16'h0000;
`endif
    bus_read(4'hA, 4'd0, rd); check("status_5stores", 32'(rd), 32'(exp_status));

    // Reset mid-conversion in sclk period 7
    adc_val = 16'h5555;
    bus_write(4'h1, 16'h0001);
    wait_cs(1'b0, "abort_start");
    idle_clks(26);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_pins", {29'd0, adc_cs_n, adc_sclk, adc_din}, 32'h4);
    bus_read(4'hA, 4'd0, rd); check("abort_status", 32'(rd), 32'h0);
    bus_read(4'h7, 4'd2, rd); check("abort_sample2", 32'(rd), 32'h0);
    bus_read(4'h8, 4'd0, rd); check("abort_seq0", 32'(rd), 32'h0);
    bus_read(4'hB, 4'd0, rd); check("abort_last_exec", 32'(rd), 32'h0);
    idle_clks(10);
    check("abort_stays_idle", 32'(adc_cs_n), 32'd1);

    // Six stores at DIVIDE=0 into a depth-4 FIFO
    adc_val = 16'h0ABC;
    base = frame_count;
    bus_write(4'h1, 16'h0003);
    wait_frames(base + 6, "fifo_timeout");
    bus_write(4'h1, 16'h0000);
    idle_clks(20);
    check("fifo_frames", 32'(frame_count), 32'(base + 6));
    check("fifo_len_div0", 32'(frame_len[base]), 32'd32);
`ifdef ADC_SEQ_FIFO_EN
    bus_read(4'hA, 4'd0, rd); check("fifo_full_ovf", 32'(rd), 32'h0404);
    bus_read(4'hC, 4'd0, rd); check("pop1", 32'(rd), 32'h0ABC);
    bus_read(4'hC, 4'd0, rd); check("pop2", 32'(rd), 32'h1ABC);
    bus_read(4'hC, 4'd0, rd); check("pop3", 32'(rd), 32'h0ABC);
    bus_read(4'hC, 4'd0, rd); check("pop4", 32'(rd), 32'h1ABC);
    bus_read(4'hC, 4'd0, rd); check("pop_empty", 32'(rd), 32'h0);
    bus_read(4'hA, 4'd0, rd); check("ovf_sticky", 32'(rd), 32'h0004);
    bus_write(4'hA, 16'h0000);
    bus_read(4'hA, 4'd0, rd); check("ovf_cleared", 32'(rd), 32'h0);
`else
    bus_read(4'hA, 4'd0, rd); check("nofifo_status", 32'(rd), 32'h0);
    bus_read(4'hC, 4'd0, rd); check("nofifo_pop", 32'(rd), 32'h0);
`endif
    bus_read(4'h8, 4'd1, rd); check("seq1_after", 32'(rd), 32'd3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
